sram_bridge: RTL and testbench

Parametrised bridge between the Wishbone slave bus, a CPU core and one OpenRAM 1rw1r macro (default 32x512). It arbitrates the RW port (port 0) between Wishbone and the core's RW requester, and round-robins `NCH` independent core read channels onto the read-only port (port 1) as a one-issue-per-cycle pipeline. It generates Wishbone acks that account for macro latency, and stalls port-1 reads that collide with a same-cycle port-0 write.

---
 rtl/sram_bridge.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sram_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: shares one OpenRAM 1rw1r macro between a Wishbone slave,
// a core RW requester (port 0) and NCH round-robin core read channels (port 1).
// Every macro-facing and requester-facing output comes straight from a flop.
module sram_bridge #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 9,
    parameter int unsigned NCH     = 2,
    parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    // Wishbone slave
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DW/8-1:0]     wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DW-1:0]       wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [DW-1:0]       wbs_dat_o,
    // core RW requester
    input  logic                c0_req,
    input  logic                c0_we,
    input  logic [DW/8-1:0]     c0_mask,
    input  logic [AW-1:0]       c0_addr,
    input  logic [DW-1:0]       c0_wdata,
    output logic                c0_gnt,
    output logic                c0_rvalid,
    output logic [DW-1:0]       c0_rdata,
    // core read channels
    input  logic [NCH-1:0]      ch_req,
    input  logic [NCH*AW-1:0]   ch_addr,
    output logic [NCH-1:0]      ch_gnt,
    output logic [NCH-1:0]      ch_rvalid,
    output logic [DW-1:0]       ch_rdata,
    // macro port 0 (RW)
    output logic                ram_csb0,
    output logic                ram_web0,
    output logic [DW/8-1:0]     ram_wmask0,
    output logic [AW-1:0]       ram_addr0,
    output logic [DW-1:0]       ram_din0,
    input  logic [DW-1:0]       ram_dout0,
    // macro port 1 (R)
    output logic                ram_csb1,
    output logic [AW-1:0]       ram_addr1,
    input  logic [DW-1:0]       ram_dout1
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        P0_IDLE  = 2'd0,
        P0_ISSUE = 2'd1,
        P0_WAIT  = 2'd2,
        P0_RESP  = 2'd3
    } p0_state_e;

    // ---------------------------------------------------------------- port 0
    p0_state_e         state_q, state_d;
    logic              src_wb_q, src_wb_d;      // 1: Wishbone owns the access
    logic              we_q, we_d;
    logic              prio_core_q, prio_core_d; // 1: core wins the next tie
    logic              csb0_q, csb0_d;
    logic              web0_q, web0_d;
    logic [MW-1:0]     wmask0_q, wmask0_d;
    logic [AW-1:0]     addr0_q, addr0_d;
    logic [DW-1:0]     din0_q, din0_d;
    logic              wb_ack_q, wb_ack_d;
    logic [DW-1:0]     wb_dat_q, wb_dat_d;
    logic              c0_gnt_q, c0_gnt_d;
    logic              c0_rvalid_q, c0_rvalid_d;
    logic [DW-1:0]     c0_rdata_q, c0_rdata_d;

    logic              wb_hit_s;
    logic              pick_wb_s;
    logic              unused_adr_s;

    assign wb_hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:AW+2] == WB_BASE[31:AW+2]);
    assign unused_adr_s = ^wbs_adr_i[1:0];

    // Port-0 state and registered pins/responses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= P0_IDLE;
            src_wb_q    <= 1'b0;
            we_q        <= 1'b0;
            prio_core_q <= 1'b0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            wb_ack_q    <= 1'b0;
            wb_dat_q    <= '0;
            c0_gnt_q    <= 1'b0;
            c0_rvalid_q <= 1'b0;
            c0_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_wb_q    <= src_wb_d;
            we_q        <= we_d;
            prio_core_q <= prio_core_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            wb_ack_q    <= wb_ack_d;
            wb_dat_q    <= wb_dat_d;
            c0_gnt_q    <= c0_gnt_d;
            c0_rvalid_q <= c0_rvalid_d;
            c0_rdata_q  <= c0_rdata_d;
        end
    end

    // Port-0 arbitration, next state and next pin/response values.
    always_comb begin
        state_d     = state_q;
        src_wb_d    = src_wb_q;
        we_d        = we_q;
        prio_core_d = prio_core_q;
        csb0_d      = 1'b1;
        web0_d      = 1'b1;
        wmask0_d    = wmask0_q;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        wb_ack_d    = 1'b0;
        wb_dat_d    = wb_dat_q;
        c0_gnt_d    = 1'b0;
        c0_rvalid_d = 1'b0;
        c0_rdata_d  = c0_rdata_q;
        pick_wb_s   = 1'b0;
        case (state_q)
            P0_IDLE: begin
                if (wb_hit_s || c0_req) begin
                    // Wishbone wins unless the core also asks and holds priority.
                    pick_wb_s   = wb_hit_s & (~c0_req | ~prio_core_q);
                    state_d     = P0_ISSUE;
                    csb0_d      = 1'b0;
                    src_wb_d    = pick_wb_s;
                    prio_core_d = pick_wb_s;
                    if (pick_wb_s) begin
                        we_d     = wbs_we_i;
                        web0_d   = ~wbs_we_i;
                        wmask0_d = wbs_sel_i;
                        addr0_d  = wbs_adr_i[AW+1:2];
                        din0_d   = wbs_dat_i;
                    end else begin
                        we_d     = c0_we;
                        web0_d   = ~c0_we;
                        wmask0_d = c0_mask;
                        addr0_d  = c0_addr;
                        din0_d   = c0_wdata;
                        c0_gnt_d = 1'b1;
                    end
                end else begin
                    state_d = P0_IDLE;
                end
            end
            P0_ISSUE: begin
                if (we_q) begin
                    // Writes respond right after the macro capture edge.
                    state_d  = P0_RESP;
                    wb_ack_d = src_wb_q & wbs_cyc_i;
                end else begin
                    state_d = P0_WAIT;
                end
            end
            P0_WAIT: begin
                state_d = P0_RESP;
                if (src_wb_q) begin
                    wb_ack_d = wbs_cyc_i;
                    wb_dat_d = ram_dout0;
                end else begin
                    c0_rvalid_d = 1'b1;
                    c0_rdata_d  = ram_dout0;
                end
            end
            P0_RESP: begin
                state_d = P0_IDLE;
            end
            default: begin
                state_d = P0_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- port 1
    logic [CW-1:0]     rr_last_q, rr_last_d;
    logic [NCH-1:0]    ch_gnt_q, ch_gnt_d;
    logic [NCH-1:0]    tag_q;
    logic [NCH-1:0]    ch_rvalid_q;
    logic [DW-1:0]     ch_rdata_q, ch_rdata_d;
    logic              csb1_q, csb1_d;
    logic [AW-1:0]     addr1_q, addr1_d;

    logic [AW-1:0]     ch_addr_a [NCH];
    logic [CW-1:0]     rr_idx_s;
    logic [CW-1:0]     cand_s;
    logic              found_s;
    logic [AW-1:0]     cand_addr_s;
    logic              collide_s;
    logic              issue_s;

    // Unpack the flat channel address bus.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            ch_addr_a[i] = ch_addr[i*AW +: AW];
        end
    end

    // Round-robin search starting after the last granted channel; an issue is
    // held off while port 0 is about to write the same word.
    always_comb begin
        found_s  = 1'b0;
        cand_s   = rr_last_q;
        rr_idx_s = rr_last_q;
        for (int k = 0; k < int'(NCH); k++) begin
            if (rr_idx_s == CW'(NCH - 1)) begin
                rr_idx_s = '0;
            end else begin
                rr_idx_s = rr_idx_s + CW'(1);
            end
            if (!found_s && ch_req[rr_idx_s]) begin
                found_s = 1'b1;
                cand_s  = rr_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        cand_addr_s = ch_addr_a[cand_s];
        collide_s   = ~csb0_d & ~web0_d & (addr0_d == cand_addr_s);
        issue_s     = found_s & ~collide_s;
        ch_gnt_d    = '0;
        if (issue_s) begin
            ch_gnt_d[cand_s] = 1'b1;
            rr_last_d        = cand_s;
            csb1_d           = 1'b0;
            addr1_d          = cand_addr_s;
        end else begin
            rr_last_d = rr_last_q;
            csb1_d    = 1'b1;
            addr1_d   = addr1_q;
        end
        if (|tag_q) begin
            ch_rdata_d = ram_dout1;
        end else begin
            ch_rdata_d = ch_rdata_q;
        end
    end

    // Port-1 pins plus the two-stage tag pipe that returns data to its channel.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rr_last_q   <= CW'(NCH - 1);
            ch_gnt_q    <= '0;
            tag_q       <= '0;
            ch_rvalid_q <= '0;
            ch_rdata_q  <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            ch_gnt_q    <= ch_gnt_d;
            tag_q       <= ch_gnt_q;
            ch_rvalid_q <= tag_q;
            ch_rdata_q  <= ch_rdata_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
        end
    end

    assign wbs_ack_o  = wb_ack_q;
    assign wbs_dat_o  = wb_dat_q;
    assign c0_gnt     = c0_gnt_q;
    assign c0_rvalid  = c0_rvalid_q;
    assign c0_rdata   = c0_rdata_q;
    assign ch_gnt     = ch_gnt_q;
    assign ch_rvalid  = ch_rvalid_q;
    assign ch_rdata   = ch_rdata_q;
    assign ram_csb0   = csb0_q;
    assign ram_web0   = web0_q;
    assign ram_wmask0 = wmask0_q;
    assign ram_addr0  = addr0_q;
    assign ram_din0   = din0_q;
    assign ram_csb1   = csb1_q;
    assign ram_addr1  = addr1_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a behavioural 1rw1r macro model.
module tb_sram_bridge;

    logic        clk;
    logic        rst_n;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_i;
    logic        wbs_ack;
    logic [31:0] wbs_dat_o;
    logic        c0_req, c0_we;
    logic [3:0]  c0_mask;
    logic [8:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic        c0_gnt, c0_rvalid;
    logic [31:0] c0_rdata;
    logic [1:0]  ch_req;
    logic [17:0] ch_addr;
    logic [1:0]  ch_gnt, ch_rvalid;
    logic [31:0] ch_rdata;
    logic        ram_csb0, ram_web0, ram_csb1;
    logic [3:0]  ram_wmask0;
    logic [8:0]  ram_addr0, ram_addr1;
    logic [31:0] ram_din0, ram_dout0, ram_dout1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:511] = '{default: 32'h0};

    sram_bridge dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
        .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_o),
        .c0_req(c0_req), .c0_we(c0_we), .c0_mask(c0_mask), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid),
        .ch_rdata(ch_rdata),
        .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
        .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0),
        .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: captures on the rising edge, dout valid after that edge.
    always @(posedge clk) begin
        if (!ram_csb0) begin
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wmask0[b]) mem[ram_addr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
                end
            end else begin
                ram_dout0 <= mem[ram_addr0];
            end
        end
        if (!ram_csb1) ram_dout1 <= mem[ram_addr1];
    end

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] wb_addr(input logic [8:0] w);
        return 32'h3000_0000 | {21'd0, w, 2'b00};
    endfunction

    task automatic wb_write(input logic [8:0] w, input logic [31:0] d, input logic [3:0] s);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_sel = s; wbs_adr = wb_addr(w); wbs_dat_i = d;
        @(negedge clk);
        chk1("wbw_csb0", ram_csb0, 1'b0);
        chk1("wbw_web0", ram_web0, 1'b0);
        chkv("wbw_addr0", 32'(ram_addr0), 32'(w));
        chkv("wbw_din0", ram_din0, d);
        chkv("wbw_wmask0", 32'(ram_wmask0), 32'(s));
        chk1("wbw_ack_early", wbs_ack, 1'b0);
        @(negedge clk);
        chk1("wbw_ack", wbs_ack, 1'b1);
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        @(negedge clk);
        chk1("wbw_ack_pulse", wbs_ack, 1'b0);
    endtask

    task automatic wb_read(input logic [8:0] w, input logic [31:0] exp_d);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0;
        wbs_sel = 4'hF; wbs_adr = wb_addr(w);
        @(negedge clk);
        chk1("wbr_csb0", ram_csb0, 1'b0);
        chk1("wbr_web0", ram_web0, 1'b1);
        chkv("wbr_addr0", 32'(ram_addr0), 32'(w));
        @(negedge clk);
        chk1("wbr_ack_wait", wbs_ack, 1'b0);
        @(negedge clk);
        chk1("wbr_ack", wbs_ack, 1'b1);
        chkv("wbr_dat", wbs_dat_o, exp_d);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(negedge clk);
        chk1("wbr_ack_pulse", wbs_ack, 1'b0);
    endtask

    task automatic core_write(input logic [8:0] a, input logic [31:0] d);
        c0_req = 1'b1; c0_we = 1'b1; c0_mask = 4'hF; c0_addr = a; c0_wdata = d;
        @(negedge clk);
        chk1("c0w_gnt", c0_gnt, 1'b1);
        chk1("c0w_web0", ram_web0, 1'b0);
        chkv("c0w_din0", ram_din0, d);
        c0_req = 1'b0;
        @(negedge clk);
        chk1("c0w_no_rvalid", c0_rvalid, 1'b0);
        chk1("c0w_no_ack", wbs_ack, 1'b0);
        @(negedge clk);
    endtask

    task automatic core_read(input logic [8:0] a, input logic [31:0] exp_d);
        c0_req = 1'b1; c0_we = 1'b0; c0_mask = 4'h0; c0_addr = a;
        @(negedge clk);
        chk1("c0r_gnt", c0_gnt, 1'b1);
        chk1("c0r_web0", ram_web0, 1'b1);
        c0_req = 1'b0;
        @(negedge clk);
        chk1("c0r_rvalid_wait", c0_rvalid, 1'b0);
        @(negedge clk);
        chk1("c0r_rvalid", c0_rvalid, 1'b1);
        chkv("c0r_rdata", c0_rdata, exp_d);
        @(negedge clk);
        chk1("c0r_rvalid_pulse", c0_rvalid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = 32'h0; wbs_dat_i = 32'h0;
        c0_req = 1'b0; c0_we = 1'b0; c0_mask = 4'h0; c0_addr = 9'd0; c0_wdata = 32'h0;
        ch_req = 2'b00; ch_addr = 18'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk1("rst_csb0", ram_csb0, 1'b1);
        chk1("rst_csb1", ram_csb1, 1'b1);
        chk1("rst_web0", ram_web0, 1'b1);
        chk1("rst_ack", wbs_ack, 1'b0);
        chk1("rst_c0_gnt", c0_gnt, 1'b0);
        chkv("rst_ch_gnt", 32'(ch_gnt), 32'd0);
        chkv("rst_wbs_dat", wbs_dat_o, 32'd0);
        chkv("rst_addr0", 32'(ram_addr0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arbitration: both requesters held; WB wins the first tie, then alternate
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'hF;
        wbs_adr = wb_addr(9'd1); wbs_dat_i = 32'h1111_1111;
        c0_req = 1'b1; c0_we = 1'b1; c0_mask = 4'hF; c0_addr = 9'd2; c0_wdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("arb_csb0", ram_csb0, 1'b0);
            chk1("arb_c0_gnt", c0_gnt, i[0]);
            chkv("arb_addr0", 32'(ram_addr0), i[0] ? 32'd2 : 32'd1);
            @(negedge clk);
            chk1("arb_ack", wbs_ack, ~i[0]);
            if (i == 3) begin
                c0_req = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
            end
            @(negedge clk);
        end
        core_read(9'd2, 32'h2222_2222);
        wb_read(9'd1, 32'h1111_1111);

        // Masked Wishbone write then read back
        wb_write(9'd5, 32'hDEAD_BEEF, 4'b0011);
        wb_read(9'd5, 32'h0000_BEEF);

        // Port-1 round robin with both channels held
        core_write(9'd3, 32'hA3A3_A3A3);
        core_write(9'd7, 32'h7777_7777);
        ch_req = 2'b11; ch_addr = {9'd7, 9'd3};
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) begin
                chk1("ch_csb1", ram_csb1, 1'b0);
                chkv("ch_addr1", 32'(ram_addr1), 32'd3);
            end
            if (t <= 6) chkv("ch_gnt", 32'(ch_gnt), t[0] ? 32'd1 : 32'd2);
            else chkv("ch_gnt_idle", 32'(ch_gnt), 32'd0);
            if (t >= 3) begin
                chkv("ch_rvalid", 32'(ch_rvalid), t[0] ? 32'd1 : 32'd2);
                chkv("ch_rdata", ch_rdata, t[0] ? 32'hA3A3_A3A3 : 32'h7777_7777);
            end
            if (t == 6) ch_req = 2'b00;
        end

        // Collision: core write and channel 0 read to word 9 in the same cycle
        c0_req = 1'b1; c0_we = 1'b1; c0_mask = 4'hF; c0_addr = 9'd9; c0_wdata = 32'h9999_0009;
        ch_req = 2'b01; ch_addr = {9'd0, 9'd9};
        @(negedge clk);
        chk1("col_c0_gnt", c0_gnt, 1'b1);
        chkv("col_ch_gnt_held", 32'(ch_gnt), 32'd0);
        chk1("col_csb1_held", ram_csb1, 1'b1);
        c0_req = 1'b0;
        @(negedge clk);
        chkv("col_ch_gnt", 32'(ch_gnt), 32'd1);
        chk1("col_csb1", ram_csb1, 1'b0);
        ch_req = 2'b00;
        @(negedge clk);
        chkv("col_rvalid_wait", 32'(ch_rvalid), 32'd0);
        @(negedge clk);
        chkv("col_rvalid", 32'(ch_rvalid), 32'd1);
        chkv("col_rdata", ch_rdata, 32'h9999_0009);
        @(negedge clk);

        // Outside the window: ignored
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h2000_0014;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk1("oow_csb0", ram_csb0, 1'b1);
            chk1("oow_ack", wbs_ack, 1'b0);
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(negedge clk);

        // cyc dropped mid-access: macro access happens, ack suppressed
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = wb_addr(9'd5);
        @(negedge clk);
        chk1("drop_csb0", ram_csb0, 1'b0);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(negedge clk);
        chk1("drop_ack_wait", wbs_ack, 1'b0);
        @(negedge clk);
        chk1("drop_ack", wbs_ack, 1'b0);
        @(negedge clk);

        // Reset pulse during WAIT of a Wishbone read, with a channel read issuing
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = wb_addr(9'd5);
        @(negedge clk);
        chk1("rstp_csb0_issue", ram_csb0, 1'b0);
        ch_req = 2'b01; ch_addr = {9'd0, 9'd3};
        @(negedge clk);
        chk1("rstp_csb1_issue", ram_csb1, 1'b0);
        ch_req = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk1("rstp_csb1_async", ram_csb1, 1'b1);
        chkv("rstp_ch_gnt_async", 32'(ch_gnt), 32'd0);
        chk1("rstp_csb0_async", ram_csb0, 1'b1);
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        @(negedge clk);
        chk1("rstp_ack", wbs_ack, 1'b0);
        chkv("rstp_rvalid", 32'(ch_rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rstp_ack_after", wbs_ack, 1'b0);
        chkv("rstp_rvalid_after", 32'(ch_rvalid), 32'd0);
        wb_read(9'd5, 32'h0000_BEEF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
